// File: rtl/regfile_2w2r.sv
// -----------------------------------------------------------------------------
// regfile_2w2r
//   Two-write / two-read architectural register file for the pipelined core.
//   All state updates on posedge clk. After reset a clear sequencer walks every
//   entry and writes zero; busy is high for that walk and both write ports are
//   ignored while it runs. With ZERO_REG=1, entry 0 always reads zero and
//   writes to it are discarded.
//
//   Build option:
//     REGFILE_BYPASS_EN  defined   -> a read of an address being written in
//                                     the same cycle returns the new write data
//                                     (port 1 has priority over port 0).
//                        undefined -> reads return the stored value only; a
//                                     write shows up the cycle after it commits.
//
// Parameters
//   DATA_W    entry width in bits
//   ADDR_W    address width, DEPTH = 1 << ADDR_W
//   ZERO_REG  1: entry 0 hardwired to zero, 0: entry 0 is ordinary
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset, restarts the clear sequence
//   busy           high while the clear sequence runs
//   we0/wa0/wd0    write port 0 (enable, address, data)
//   we1/wa1/wd1    write port 1; wins over port 0 on an address collision
//   ra1/rd1        read port 1 (combinational)
//   ra2/rd2        read port 2 (combinational)
// -----------------------------------------------------------------------------
module regfile_2w2r #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd2
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rf [DEPTH];

  logic we0_ok, we1_ok;
  logic hit0_1, hit1_1, hit0_2, hit1_2;

  // ---------------------------------------------------------------------------
  // Clear sequencer: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear sequencer: next state
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          // Last entry is zeroed on this edge; counter parks at 0.
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN:     ;
      default: state_d = CLEAR;
    endcase
  end

  assign busy = (state_q == CLEAR);

  // A write commits only in RUN and never to the hardwired zero entry.
  assign we0_ok = !busy && we0 && !((ZERO_REG != 0) && (wa0 == '0));
  assign we1_ok = !busy && we1 && !((ZERO_REG != 0) && (wa1 == '0));

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch so it maps onto plain flops/RAM;
  // the clear sequencer provides the known-zero contents instead.
  always_ff @(posedge clk) begin
    if (busy) begin
      rf[cnt_q] <= '0;
    end else begin
      if (we0_ok) rf[wa0] <= wd0;
      // Issued after port 0 so that on a collision port 1's value lands.
      if (we1_ok) rf[wa1] <= wd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
  assign hit0_1 = we0_ok && (wa0 == ra1);
  assign hit1_1 = we1_ok && (wa1 == ra1);
  assign hit0_2 = we0_ok && (wa0 == ra2);
  assign hit1_2 = we1_ok && (wa1 == ra2);
`else
  assign hit0_1 = 1'b0;
  assign hit1_1 = 1'b0;
  assign hit0_2 = 1'b0;
  assign hit1_2 = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] read_port(
    input logic              blk,
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              hit0,
    input logic              hit1,
    input logic [DATA_W-1:0] d0,
    input logic [DATA_W-1:0] d1
  );
    logic [DATA_W-1:0] r;
    r = stored;
    if (hit0) r = d0;
    if (hit1) r = d1;
    // Zero while clearing and for the hardwired entry; also keeps X off the
    // outputs before the first clear has finished.
    if (blk || ((ZERO_REG != 0) && (ra == '0))) r = '0;
    return r;
  endfunction

  assign rd1 = read_port(busy, ra1, rf[ra1], hit0_1, hit1_1, wd0, wd1);
  assign rd2 = read_port(busy, ra2, rf[ra2], hit0_2, hit1_2, wd0, wd1);

endmodule

// File: tb/tb_regfile_2w2r.sv
// -----------------------------------------------------------------------------
// tb_regfile_2w2r
//   Directed bench for regfile_2w2r. Two instances share all inputs: dut_z
//   with ZERO_REG=1 and dut_n with ZERO_REG=0. Expected values are written
//   out by hand; the bypass-dependent ones follow REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_regfile_2w2r;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1;
  logic [4:0]  wa0, wa1, ra1, ra2;
  logic [31:0] wd0, wd1;
  logic        busy_z, busy_n;
  logic [31:0] rd1_z, rd2_z, rd1_n, rd2_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .busy(busy_z),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .rd1(rd1_z), .ra2(ra2), .rd2(rd2_z)
  );

  regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_n (
    .clk(clk), .rst(rst), .busy(busy_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .rd1(rd1_n), .ra2(ra2), .rd2(rd2_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle
  // well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0;
  endtask

  // Count edges until busy drops, bounded so a stuck sequencer still ends.
  task automatic wait_clear(output int n);
    n = 0;
    while (busy_z === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, 8'hA5, ~b, 8'h3C};
  endfunction

  int n;

  initial begin
    rst = 1'b1; idle();
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra1 = '0; ra2 = '0;

    // ---- reset and clear --------------------------------------------------
    tick();
    rst = 1'b0;
    settle();
    check("busy_after_rst", 32'(busy_z), 32'd1);
    // Writes during the clear must be dropped, reads forced to zero.
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000DEAD; ra1 = 5'd3; ra2 = 5'd17;
    settle();
    check("rd1_busy", rd1_z, 32'h0);
    check("rd2_busy_nz", rd2_n, 32'h0);
    wait_clear(n);
    idle();
    check("clear_cycles", 32'(n), 32'd32);
    check("busy_n_done", 32'(busy_n), 32'd0);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      settle();
      check($sformatf("clr_rd1_%0d", i), rd1_z, 32'h0);
      check($sformatf("clr_rd2_n_%0d", 31 - i), rd2_n, 32'h0);
    end
    ra1 = 5'd3; settle();
    check("rf3_not_written", rd1_n, 32'h0);

    // ---- dual write --------------------------------------------------------
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd6; wd1 = 32'h22;
    tick(); idle();
    ra1 = 5'd5; ra2 = 5'd6; settle();
    check("dual_rd1", rd1_z, 32'h11);
    check("dual_rd2", rd2_z, 32'h22);

    // Collision: port 1 wins, both on bypass and in storage.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2;
    ra1 = 5'd7; settle();
    check("coll_same_cycle", rd1_z, BYP ? 32'h2 : 32'h0);
    tick(); idle(); settle();
    check("coll_stored", rd1_z, 32'h2);

    // ---- zero register -----------------------------------------------------
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; ra1 = 5'd0; settle();
    check("zero_same_z", rd1_z, 32'h0);
    check("zero_same_n", rd1_n, BYP ? 32'hFFFFFFFF : 32'h0);
    tick(); idle(); settle();
    check("zero_next_z", rd1_z, 32'h0);
    check("zero_next_n", rd1_n, 32'hFFFFFFFF);

    // ---- bypass ------------------------------------------------------------
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hAAAA;
    tick(); idle();
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h5555; ra1 = 5'd9; ra2 = 5'd9; settle();
    check("byp_rd1_same", rd1_z, BYP ? 32'h5555 : 32'hAAAA);
    check("byp_rd2_same", rd2_z, BYP ? 32'h5555 : 32'hAAAA);
    tick(); idle(); settle();
    check("byp_rd1_next", rd1_z, 32'h5555);
    // Port 0 bypass must not fire for an unrelated address.
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h9999; ra1 = 5'd9; settle();
    check("byp_other_addr", rd1_z, 32'h5555);
    tick(); idle();

    // ---- fill every entry, alternating ports --------------------------------
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 1) begin
        we0 = 1'b1; wa0 = 5'(i); wd0 = pat(i);
      end else begin
        we1 = 1'b1; wa1 = 5'(i); wd1 = pat(i);
      end
      tick(); idle();
    end
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i); settle();
      check($sformatf("fill_rd1_z_%0d", i), rd1_z, (i == 0) ? 32'h0 : pat(i));
      check($sformatf("fill_rd2_n_%0d", 31 - i), rd2_n, pat(31 - i));
    end

    // ---- reset in the middle of a clear -------------------------------------
    we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h77;
    tick(); idle();
    ra1 = 5'd12; settle();
    check("rf12_written", rd1_z, 32'h77);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    settle();
    check("busy_mid_clear", 32'(busy_z), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    wait_clear(n);
    check("reclear_cycles", 32'(n), 32'd32);
    ra1 = 5'd12; ra2 = 5'd31; settle();
    check("rf12_cleared_z", rd1_z, 32'h0);
    check("rf12_cleared_n", rd1_n, 32'h0);
    check("rf31_cleared_n", rd2_n, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
